// File: rtl/tohost_monitor.sv
// -----------------------------------------------------------------------------
// tohost_monitor
//
// Test-completion responder on the core's data-store path. Watches for stores
// to the riscv-tests `tohost` word and latches a single sticky verdict (pass,
// fail with test number, or watchdog timeout) so the harness can poll one
// done/pass pair. Also reports how many cycles the run took, frozen at the
// verdict.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   wr_en      in   1      store valid, one cycle per store
//   wr_addr    in   32     store byte address
//   wr_data    in   32     store data (full word)
//   wr_ack     out  1      one-cycle pulse per accepted tohost store
//   done       out  1      sticky, a verdict has been reached
//   pass       out  1      sticky, meaningful when done=1
//   timeout    out  1      sticky, the verdict came from the watchdog
//   fail_test  out  31     failing test number (wr_data[31:1])
//   cycles     out  CNT_W  cycles spent running, frozen once done
// -----------------------------------------------------------------------------
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic             wr_ack,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      fail_test,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  // Counter value at which the watchdog fires on the next edge.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      fail_test_q, fail_test_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic hit;

  // wr_en gates the compare, so X on the address bus while idle resolves to 0.
  assign hit = wr_en && (wr_addr == TOHOST_ADDR);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d     = state_q;
    fail_test_d = fail_test_q;
    cycles_d    = cycles_q;
    ack_d       = hit;

    if (state_q == S_RUN) begin
      if (cycles_q != '1) begin
        cycles_d = cycles_q + CNT_W'(1);
      end

      // A verdict in the data beats a watchdog expiry on the same edge; a
      // clear or syscall-style value falls through and lets the timeout fire.
      if (hit && (wr_data == 32'd1)) begin
        state_d = S_PASS;
      end else if (hit && wr_data[0]) begin
        state_d     = S_FAIL;
        fail_test_d = wr_data[31:1];
      end else if (cycles_q == WDOG_LAST) begin
        state_d = S_TIMEOUT;
      end
    end

    // Flags are decoded from the next state and registered alongside it, so
    // the outputs are plain flops.
    done_d    = (state_d != S_RUN);
    pass_d    = (state_d == S_PASS);
    timeout_d = (state_d == S_TIMEOUT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_test_q <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_test_q <= fail_test_d;
      cycles_q    <= cycles_d;
    end
  end

  assign wr_ack    = ack_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_test = fail_test_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// -----------------------------------------------------------------------------
// tb_tohost_monitor
//
// Two monitors share one stimulus stream: one with the default 5000-cycle
// watchdog and one with a 20-cycle watchdog so timeout behaviour is reachable.
// A behavioural model per instance tracks the verdict, the count of running
// edges since reset and the ack pulse; each scenario task compares both DUTs
// against it after every edge, plus targeted checks on fixed expected values.
// -----------------------------------------------------------------------------
module tb_tohost_monitor;

  localparam logic [31:0] ADDR  = 32'h0000_1000;
  localparam int          TMO_A = 5000;
  localparam int          TMO_B = 20;

  // Verdict codes of the reference model.
  localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2, V_TMO = 3;

  typedef struct {
    int          verdict;
    bit          ack;
    bit [30:0]   ft;
    longint      cyc;
  } model_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        ack_a, done_a, pass_a, to_a;
  logic [30:0] ft_a;
  logic [31:0] cyc_a;
  logic        ack_b, done_b, pass_b, to_b;
  logic [30:0] ft_b;
  logic [31:0] cyc_b;

  int vectors     = 0;
  int miscompares = 0;

  model_t ma, mb;

  always #5 clk = ~clk;

  tohost_monitor #(.TOHOST_ADDR(ADDR), .TIMEOUT_CYCLES(TMO_A), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(ack_a), .done(done_a), .pass(pass_a), .timeout(to_a),
    .fail_test(ft_a), .cycles(cyc_a)
  );

  tohost_monitor #(.TOHOST_ADDR(ADDR), .TIMEOUT_CYCLES(TMO_B), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(ack_b), .done(done_b), .pass(pass_b), .timeout(to_b),
    .fail_test(ft_b), .cycles(cyc_b)
  );

  wire [133:0] obs = {ack_a, done_a, pass_a, to_a, ft_a, cyc_a,
                      ack_b, done_b, pass_b, to_b, ft_b, cyc_b};

  function automatic model_t step(model_t m, int tmo, bit r, logic en,
                                  logic [31:0] a, logic [31:0] d);
    model_t n = m;
    bit     h = 1'b0;
    if (r) begin
      n.verdict = V_RUN; n.ack = 1'b0; n.ft = '0; n.cyc = 0;
      return n;
    end
    if (en === 1'b1) h = (a === ADDR);
    n.ack = h;
    if (m.verdict == V_RUN) begin
      if (m.cyc < 64'h0000_0000_FFFF_FFFF) n.cyc = m.cyc + 1;
      if (h && d == 32'd1)       n.verdict = V_PASS;
      else if (h && d[0])        begin n.verdict = V_FAIL; n.ft = d[31:1]; end
      else if (m.cyc == tmo - 1) n.verdict = V_TMO;
    end
    return n;
  endfunction

  function automatic logic [66:0] pack(model_t m);
    logic [31:0] c = m.cyc[31:0];
    return {m.ack, m.verdict != V_RUN, m.verdict == V_PASS, m.verdict == V_TMO,
            m.ft, c};
  endfunction

  // Drive one cycle of stimulus, advance the models, settle just after the edge.
  task automatic apply(input bit r, input logic en, input logic [31:0] a,
                       input logic [31:0] d);
    rst = r; wr_en = en; wr_addr = a; wr_data = d;
    @(posedge clk);
    ma = step(ma, TMO_A, r, en, a, d);
    mb = step(mb, TMO_B, r, en, a, d);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 'x, 'x);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, ADDR, 32'd1);
    apply(1'b1, 1'b0, 'x, 'x);
    vectors++;
    if (obs !== {pack(ma), pack(mb)}) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obs, {pack(ma), pack(mb)});
    end
    vectors++;
    if ({ack_a, done_a, pass_a, to_a, ft_a, cyc_a} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_zero: got %h want 0", {ack_a, done_a, pass_a, to_a, ft_a, cyc_a});
    end
  endtask

  task automatic test_pass();
    apply(1'b1, 1'b0, 'x, 'x);
    for (int i = 0; i < 150; i++) begin
      if (i == 99) apply(1'b0, 1'b1, ADDR, 32'd1);
      else         idle();
      vectors++;
      if (obs !== {pack(ma), pack(mb)}) begin
        miscompares++;
        $display("FAIL pass_seq[%0d]: got %h want %h", i, obs, {pack(ma), pack(mb)});
      end
      if (i == 99 || i == 100) begin
        vectors++;
        if ({ack_a, done_a, pass_a} !== {i == 99, 1'b1, 1'b1}) begin
          miscompares++;
          $display("FAIL pass_flags[%0d]: got %b want %b", i, {ack_a, done_a, pass_a},
                   {i == 99, 1'b1, 1'b1});
        end
      end
    end
    vectors++;
    if (cyc_a !== 32'd100) begin
      miscompares++;
      $display("FAIL pass_cycles_frozen: got %0d want 100", cyc_a);
    end
  endtask

  task automatic test_fail();
    apply(1'b1, 1'b0, 'x, 'x);
    idle();
    apply(1'b0, 1'b1, ADDR, 32'h0000_0007);
    vectors++;
    if ({done_a, pass_a, to_a, ft_a} !== {3'b100, 31'd3}) begin
      miscompares++;
      $display("FAIL fail_verdict: got %b/%0d want 100/3", {done_a, pass_a, to_a}, ft_a);
    end
    idle();
    apply(1'b0, 1'b1, ADDR, 32'h0000_0001);
    vectors++;
    if ({ack_a, pass_a, ft_a} !== {2'b10, 31'd3}) begin
      miscompares++;
      $display("FAIL fail_sticky: got %b/%0d want 10/3", {ack_a, pass_a}, ft_a);
    end
    vectors++;
    if (obs !== {pack(ma), pack(mb)}) begin
      miscompares++;
      $display("FAIL fail_model: got %h want %h", obs, {pack(ma), pack(mb)});
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs = '{ADDR + 32'd4, ADDR - 32'd4, ADDR};
    datas = '{32'd1, 32'd1, 32'd0};
    apply(1'b1, 1'b0, 'x, 'x);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, addrs[i], datas[i]);
      vectors++;
      if ({ack_a, done_a} !== {i == 2, 1'b0}) begin
        miscompares++;
        $display("FAIL decode[%0d]: got ack/done %b want %b", i, {ack_a, done_a}, {i == 2, 1'b0});
      end
      vectors++;
      if (obs !== {pack(ma), pack(mb)}) begin
        miscompares++;
        $display("FAIL decode_model[%0d]: got %h want %h", i, obs, {pack(ma), pack(mb)});
      end
    end
  endtask

  task automatic test_timeout();
    // Plain expiry on the 20-cycle instance.
    apply(1'b1, 1'b0, 'x, 'x);
    for (int i = 1; i <= 22; i++) begin
      idle();
      vectors++;
      if (obs !== {pack(ma), pack(mb)}) begin
        miscompares++;
        $display("FAIL timeout_seq[%0d]: got %h want %h", i, obs, {pack(ma), pack(mb)});
      end
    end
    vectors++;
    if ({done_b, to_b, pass_b, cyc_b} !== {3'b110, 32'd20}) begin
      miscompares++;
      $display("FAIL timeout_final: got %b/%0d want 110/20", {done_b, to_b, pass_b}, cyc_b);
    end
    // A pass store on exactly the expiry edge wins.
    apply(1'b1, 1'b0, 'x, 'x);
    for (int i = 1; i < 20; i++) idle();
    apply(1'b0, 1'b1, ADDR, 32'd1);
    vectors++;
    if ({done_b, pass_b, to_b, cyc_b} !== {3'b110, 32'd20}) begin
      miscompares++;
      $display("FAIL timeout_vs_pass: got %b/%0d want 110/20", {done_b, pass_b, to_b}, cyc_b);
    end
    // A clear on the expiry edge still lets the watchdog fire.
    apply(1'b1, 1'b0, 'x, 'x);
    for (int i = 1; i < 20; i++) idle();
    apply(1'b0, 1'b1, ADDR, 32'd0);
    vectors++;
    if ({ack_b, done_b, to_b} !== 3'b111) begin
      miscompares++;
      $display("FAIL timeout_vs_clear: got %b want 111", {ack_b, done_b, to_b});
    end
  endtask

  task automatic test_mid_reset();
    apply(1'b1, 1'b0, 'x, 'x);
    idle();
    apply(1'b0, 1'b1, ADDR, 32'h0000_0005);
    vectors++;
    if ({ack_a, done_a, ft_a} !== {2'b11, 31'd2}) begin
      miscompares++;
      $display("FAIL mid_fail: got %b/%0d want 11/2", {ack_a, done_a}, ft_a);
    end
    apply(1'b1, 1'b1, ADDR, 32'h0000_0001);
    vectors++;
    if (obs !== 134'd0) begin
      miscompares++;
      $display("FAIL mid_reset_zero: got %h want 0", obs);
    end
    idle();
    vectors++;
    if (cyc_a !== 32'd1) begin
      miscompares++;
      $display("FAIL mid_restart: got %0d want 1", cyc_a);
    end
    apply(1'b0, 1'b1, ADDR, 32'h0000_0001);
    vectors++;
    if ({done_a, pass_a, cyc_a} !== {2'b11, 32'd2}) begin
      miscompares++;
      $display("FAIL mid_pass: got %b/%0d want 11/2", {done_a, pass_a}, cyc_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq = '{32'd0, 32'd0, 32'd1};
    apply(1'b1, 1'b0, 'x, 'x);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) apply(1'b0, 1'b1, ADDR, seq[i]);
      else       idle();
      vectors++;
      if ({ack_a, pass_a} !== {i < 3, i >= 2}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got ack/pass %b want %b", i, {ack_a, pass_a}, {i < 3, i >= 2});
      end
    end
  endtask

  task automatic test_random();
    logic        en;
    logic [31:0] a, d;
    bit          r;
    apply(1'b1, 1'b0, 'x, 'x);
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      en = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1:    a = ADDR;
        2:       a = ADDR ^ (32'd1 << $urandom_range(0, 31));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       d = 32'd0;
        1:       d = 32'd1;
        2:       d = $urandom | 32'd1;
        default: d = $urandom & ~32'd1;
      endcase
      if (!en && $urandom_range(0, 1) == 1) begin
        a = 'x;
        d = 'x;
      end
      apply(r, en, a, d);
      vectors++;
      if (obs !== {pack(ma), pack(mb)}) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, {pack(ma), pack(mb)});
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ma = '{verdict: V_RUN, ack: 1'b0, ft: '0, cyc: 0};
    mb = ma;
    test_reset();
    test_pass();
    test_fail();
    test_decode();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
- Memory-mapped test-completion responder on the core's data-write path.
- Decodes stores the core issues to the riscv-tests `tohost` word and latches the verdict: pass, fail with test number, or watchdog timeout.
- Gives the simulation harness one sticky `done`/`pass` pair instead of probing core internals.
- Also exposes a frozen cycle count for run-length reporting.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word; full 32-bit compare.
- TIMEOUT_CYCLES, 5000, run cycles allowed before a timeout verdict; must be ≥ 2.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  core data-store valid, one cycle per store.
- wr_addr  in  32  store byte address.
- wr_data  in  32  store data; full-word stores only.
- wr_ack  out  1  one-cycle pulse acknowledging an accepted tohost store.
- done  out  1  sticky; verdict reached.
- pass  out  1  sticky; valid when done=1.
- timeout  out  1  sticky; done was caused by the watchdog.
- fail_test  out  31  failing test number, from wr_data[31:1].
- cycles  out  CNT_W  cycles spent in RUN; frozen once done.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is sampled only on the rising edge of clk.
  - rst wins over every other input.
- Reset values: state=RUN, wr_ack=0, done=0, pass=0, timeout=0, fail_test=0, cycles=0.
- All outputs are registered. Nothing is combinational from the inputs.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until rst.
- done = (state != RUN).
- Tohost hit = wr_en=1 and wr_addr==TOHOST_ADDR. Any other address is ignored: no ack, no state change.
- Hit in RUN, sampled at edge N; all effects are visible after edge N (latency 1):
  - wr_data==0 (tohost clear): wr_ack=1 for one cycle; stay in RUN.
  - wr_data==1: go to PASS; pass=1; wr_ack=1.
  - wr_data[0]==1 and wr_data!=1: go to FAIL; fail_test=wr_data[31:1]; pass=0; wr_ack=1.
  - wr_data[0]==0 and wr_data!=0 (syscall-style value): wr_ack=1; stay in RUN; value discarded.
- Hit in a terminal state: wr_ack pulses. Verdict, fail_test and cycles are unchanged; the first verdict wins.
- wr_ack deasserts on the next edge unless another hit occurs. Back-to-back hits produce back-to-back ack cycles.
- Cycle counter:
  - Increments by 1 on every edge while in RUN and not in rst.
  - Saturates at all-ones.
  - Holds its value once the state leaves RUN.
- Watchdog:
  - In RUN, if cycles==TIMEOUT_CYCLES-1 at an edge and no verdict-producing hit occurs on that edge: go to TIMEOUT; timeout=1; pass=0.
  - The final cycles value is TIMEOUT_CYCLES.
- Simultaneous hit and watchdog expiry on the same edge: the hit is processed (PASS/FAIL, or a clear/syscall value). Only a non-verdict hit also allows the timeout on that edge, so the data verdict has priority.
- Reset mid-operation, including from a terminal state or during an ack pulse: all outputs return to reset values on that edge. Counting restarts from 0 on the first edge after rst deasserts.
- X on wr_addr/wr_data while wr_en=0 must not affect state.

Test Plan:
- Reset, then a store to TOHOST_ADDR with 32'h1 at cycle 100:
  - done=1, pass=1 one cycle later; wr_ack is a single-cycle pulse.
  - cycles frozen at its value at the time of the store; stays constant for 50 more cycles.
- Store to TOHOST_ADDR with 32'h0000_0007:
  - done=1, pass=0, fail_test=3, timeout=0.
  - A following store of 32'h1 acks but leaves pass=0 and fail_test=3.
- Stores of 32'h1 to TOHOST_ADDR+4 and TOHOST_ADDR-4 → no wr_ack, done=0. A clear (data 0) to TOHOST_ADDR → wr_ack pulse, done=0.
- Timeout with TIMEOUT_CYCLES=20 and no stores:
  - done=timeout=1 after the edge where cycles was 19; cycles=20; pass=0.
  - A store of 32'h1 on exactly that edge → PASS, timeout=0.
- Reset in the middle:
  - Reach FAIL (data 32'h5 → fail_test=2), then assert rst for one cycle → every output returns to 0.
  - cycles restarts from 0; a subsequent data 32'h1 → PASS.
- Back-to-back tohost stores of 0, 0, 1 on consecutive cycles → wr_ack high for three consecutive cycles; pass=1 after the third.
